// File: rtl/irq_pkg.sv
// Shared sizes, types and helpers for the IRQ/EOI pad frontend.
// Line count and id width are fixed here so every file agrees on vector shapes.
package irq_pkg;

  localparam int NUM_IRQ = 16;
  localparam int ID_W    = $clog2(NUM_IRQ);

  typedef logic [NUM_IRQ-1:0] irq_vec_t;
  typedef logic [ID_W-1:0]    irq_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } offer_state_e;

  typedef enum logic {
    E_IDLE  = 1'b0,
    E_PULSE = 1'b1
  } eoi_state_e;

  // Lowest set index wins; an all-zero vector yields 0 and callers gate on |v.
  function automatic irq_id_t prio_enc(input irq_vec_t v);
    irq_id_t id;
    id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) id = irq_id_t'(i);
    end
    return id;
  endfunction

  function automatic logic id_in_range(input irq_id_t id);
    return (int'(id) < NUM_IRQ);
  endfunction

  function automatic irq_vec_t id_onehot(input irq_id_t id);
    irq_vec_t v;
    v = '0;
    if (id_in_range(id)) v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Brings one asynchronous pad level into clk and flags its rising edge for one cycle.
// Rise is combinational off the last two flops, so it appears SYNC_STAGES edges after the pad.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic pad_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_eoi_frontend.sv
// Pad-side interrupt frontend: edge-latched pending lines offered by priority over valid/ready,
// in-service tracking, and fixed-width one-hot EOI pad pulses driven from SOC end-of-interrupt.
module irq_eoi_frontend
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EOI_PULSE   = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_IRQ-1:0] irq_pad,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ready,
  input  logic               eoi_valid,
  input  logic [ID_W-1:0]    eoi_id,
  output logic               eoi_ready,
  output logic               eoi_err,
  output logic [NUM_IRQ-1:0] eoi_pad
);

  localparam int CNT_W = (EOI_PULSE > 1) ? $clog2(EOI_PULSE) : 1;

  irq_vec_t     rise;
  irq_vec_t     eligible;
  irq_vec_t     accept_vec;
  irq_vec_t     eoi_clr_vec;

  irq_vec_t     pending_q, pending_d;
  irq_vec_t     in_service_q, in_service_d;

  offer_state_e offer_state_q, offer_state_d;
  irq_id_t      offer_id_q, offer_id_d;

  eoi_state_e   eoi_state_q, eoi_state_d;
  irq_id_t      pad_id_q, pad_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .rstn   (rstn),
      .pad_i  (irq_pad[g]),
      .rise_o (rise[g])
    );
  end

  assign eligible = pending_q & ~in_service_q & ~irq_mask;

  // Once an offer is up its id is frozen until accepted, regardless of mask or new edges.
  always_comb begin
    offer_state_d = offer_state_q;
    offer_id_d    = offer_id_q;
    accept_vec    = '0;
    irq_valid     = 1'b0;
    case (offer_state_q)
      IDLE: begin
        if (|eligible) begin
          offer_id_d    = prio_enc(eligible);
          offer_state_d = OFFER;
        end
      end
      OFFER: begin
        irq_valid = 1'b1;
        if (irq_ready) begin
          accept_vec    = id_onehot(offer_id_q);
          offer_state_d = IDLE;
        end
      end
      default: offer_state_d = IDLE;
    endcase
  end

  assign irq_id = offer_id_q;

  always_comb begin
    eoi_state_d = eoi_state_q;
    pad_id_d    = pad_id_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    eoi_clr_vec = '0;
    eoi_ready   = 1'b0;
    eoi_pad     = '0;
    case (eoi_state_q)
      E_IDLE: begin
        eoi_ready = 1'b1;
        if (eoi_valid) begin
          if (id_in_range(eoi_id) && in_service_q[eoi_id]) begin
            eoi_clr_vec = id_onehot(eoi_id);
            pad_id_d    = eoi_id;
            cnt_d       = CNT_W'(EOI_PULSE - 1);
            eoi_state_d = E_PULSE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      E_PULSE: begin
        eoi_pad = id_onehot(pad_id_q);
        if (cnt_q == '0) begin
          eoi_state_d = E_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: eoi_state_d = E_IDLE;
    endcase
  end

  assign eoi_err = err_q;

  // A new edge on the line being accepted keeps it pending, so nothing is lost.
  assign pending_d    = (pending_q & ~accept_vec) | rise;
  assign in_service_d = (in_service_q | accept_vec) & ~eoi_clr_vec;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_q     <= '0;
      in_service_q  <= '0;
      offer_state_q <= IDLE;
      offer_id_q    <= '0;
      eoi_state_q   <= E_IDLE;
      pad_id_q      <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      in_service_q  <= in_service_d;
      offer_state_q <= offer_state_d;
      offer_id_q    <= offer_id_d;
      eoi_state_q   <= eoi_state_d;
      pad_id_q      <= pad_id_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_irq_eoi_frontend.sv
// Directed bench for irq_eoi_frontend: reset, single IRQ/EOI, priority, mask, re-raise, error.
module tb_irq_eoi_frontend;
  import irq_pkg::*;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NUM_IRQ-1:0] irq_pad;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;
  logic               irq_ready;
  logic               eoi_valid;
  logic [ID_W-1:0]    eoi_id;
  logic               eoi_ready;
  logic               eoi_err;
  logic [NUM_IRQ-1:0] eoi_pad;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_eoi_frontend #(
    .SYNC_STAGES (2),
    .EOI_PULSE   (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .irq_pad   (irq_pad),
    .irq_mask  (irq_mask),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
    .eoi_valid (eoi_valid),
    .eoi_id    (eoi_id),
    .eoi_ready (eoi_ready),
    .eoi_err   (eoi_err),
    .eoi_pad   (eoi_pad)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!irq_valid && n < 20) begin
      step(1);
      n++;
    end
    chk(tag, 32'(irq_valid), 32'd1);
  endtask

  task automatic accept();
    irq_ready = 1'b1;
    step(1);
    irq_ready = 1'b0;
    chk("acc_drop", 32'(irq_valid), 32'd0);
  endtask

  task automatic pulse_pad(input int idx);
    irq_pad[idx] = 1'b1;
    step(3);
    irq_pad[idx] = 1'b0;
  endtask

  task automatic do_eoi(input int id);
    int n;
    n = 0;
    while (!eoi_ready && n < 20) begin
      step(1);
      n++;
    end
    eoi_valid = 1'b1;
    eoi_id    = ID_W'(id);
    step(1);
    eoi_valid = 1'b0;
    n = 0;
    while (!eoi_ready && n < 20) begin
      step(1);
      n++;
    end
    chk("eoi_done", 32'(eoi_ready), 32'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    irq_pad   = 16'hFFFF;
    irq_mask  = '0;
    irq_ready = 1'b0;
    eoi_valid = 1'b0;
    eoi_id    = '0;

    // 1: reset values with all pads high, then one offer per line in index order
    step(3);
    chk("rst_valid", 32'(irq_valid), 32'd0);
    chk("rst_id",    32'(irq_id),    32'd0);
    chk("rst_eoi_rdy", 32'(eoi_ready), 32'd1);
    chk("rst_err",   32'(eoi_err),   32'd0);
    chk("rst_pad",   32'(eoi_pad),   32'd0);
    rstn = 1'b1;
    for (int k = 0; k < NUM_IRQ; k++) begin
      wait_valid("all_to");
      chk("all_id", 32'(irq_id), 32'(k));
      accept();
    end
    step(10);
    chk("all_nodup", 32'(irq_valid), 32'd0);
    irq_pad = '0;
    do_reset();

    // 2: single IRQ on line 5, offer exactly SYNC_STAGES+2 edges after the pad rises
    irq_pad[5] = 1'b1;
    step(3);
    chk("s5_early", 32'(irq_valid), 32'd0);
    step(1);
    chk("s5_valid", 32'(irq_valid), 32'd1);
    chk("s5_id",    32'(irq_id),    32'd5);
    irq_pad[5] = 1'b0;
    accept();
    eoi_valid = 1'b1;
    eoi_id    = 4'd5;
    step(1);
    eoi_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("s5_pad", 32'(eoi_pad),   32'h0020);
      chk("s5_rdy", 32'(eoi_ready), 32'd0);
      step(1);
    end
    chk("s5_pad_end", 32'(eoi_pad),   32'h0000);
    chk("s5_rdy_end", 32'(eoi_ready), 32'd1);
    chk("s5_noerr",   32'(eoi_err),   32'd0);

    // 3: a higher-priority edge does not disturb an outstanding offer
    pulse_pad(9);
    wait_valid("p9_to");
    chk("p9_id", 32'(irq_id), 32'd9);
    pulse_pad(2);
    step(5);
    chk("p9_hold_v",  32'(irq_valid), 32'd1);
    chk("p9_hold_id", 32'(irq_id),    32'd9);
    accept();
    wait_valid("p2_to");
    chk("p2_id", 32'(irq_id), 32'd2);
    accept();
    do_eoi(9);
    do_eoi(2);

    // 4: masked line stays pending and is offered once unmasked
    irq_mask[3] = 1'b1;
    pulse_pad(3);
    step(8);
    chk("m3_blocked", 32'(irq_valid), 32'd0);
    irq_mask[3] = 1'b0;
    wait_valid("m3_to");
    chk("m3_id", 32'(irq_id), 32'd3);
    accept();
    do_eoi(3);

    // 5: re-raise during service is held until EOI
    pulse_pad(7);
    wait_valid("r7_to");
    chk("r7_id", 32'(irq_id), 32'd7);
    accept();
    pulse_pad(7);
    step(8);
    chk("r7_blocked", 32'(irq_valid), 32'd0);
    do_eoi(7);
    wait_valid("r7b_to");
    chk("r7b_id", 32'(irq_id), 32'd7);
    accept();
    do_eoi(7);

    // 6: EOI for a line not in service, then reset in the middle of a pulse
    eoi_valid = 1'b1;
    eoi_id    = 4'd12;
    step(1);
    eoi_valid = 1'b0;
    chk("e12_err", 32'(eoi_err),   32'd1);
    chk("e12_pad", 32'(eoi_pad),   32'd0);
    chk("e12_rdy", 32'(eoi_ready), 32'd1);
    step(1);
    chk("e12_err_end", 32'(eoi_err), 32'd0);

    pulse_pad(1);
    wait_valid("x1_to");
    chk("x1_id", 32'(irq_id), 32'd1);
    accept();
    pulse_pad(4);
    eoi_valid = 1'b1;
    eoi_id    = 4'd1;
    step(1);
    eoi_valid = 1'b0;
    chk("x1_pad", 32'(eoi_pad), 32'h0002);
    rstn = 1'b0;
    #1;
    chk("x_rst_pad",   32'(eoi_pad),   32'd0);
    chk("x_rst_rdy",   32'(eoi_ready), 32'd1);
    chk("x_rst_valid", 32'(irq_valid), 32'd0);
    step(1);
    rstn = 1'b1;
    step(10);
    chk("x_pend_clr", 32'(irq_valid), 32'd0);
    eoi_valid = 1'b1;
    eoi_id    = 4'd4;
    step(1);
    eoi_valid = 1'b0;
    chk("x_insvc_clr", 32'(eoi_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
